// File: rtl/mult_div_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
// The pipeline side is the master; the multiply/divide unit is the slave.
interface mult_div_if;
    logic [31:0] A;      // operand A: dividend / multiplicand
    logic [31:0] B;      // operand B: divisor / multiplier
    logic [1:0]  OP;     // 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
    logic        start;  // request, sampled only while idle
    logic [31:0] HI;     // product[63:32] or remainder
    logic [31:0] LO;     // product[31:0] or quotient
    logic        busy;   // unit is not idle; pipeline stalls on it
    logic        done;   // one-cycle pulse when HI/LO hold a new result
    logic        dz;     // divide-by-zero flag, meaningful only with done

    modport master (
        output A, B, OP, start,
        input  HI, LO, busy, done, dz
    );

    modport slave (
        input  A, B, OP, start,
        output HI, LO, busy, done, dz
    );
endinterface

// File: rtl/mult_div.sv
// Iterative 32x32 multiply (shift-add) and 32/32 divide (restoring) unit.
// A request latches the operands, spends one CALC cycle forming operand
// magnitudes, then 32 CALC cycles producing one bit each; the sign-corrected
// result is written to HI/LO on the final CALC edge and announced by a
// one-cycle DONE state. A divide by zero skips CALC and only raises dz.
module mult_div (
    input  logic       clock,
    input  logic       reset,
    mult_div_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;       // iteration counter, 0..31
    logic        prep_q;      // first CALC cycle: form magnitudes
    logic [31:0] a_q;         // latched operand A
    logic [31:0] b_q;         // latched operand B
    logic [1:0]  op_q;        // latched operation
    logic [31:0] ma_q;        // |A| (multiplicand) or unused for divide
    logic [31:0] mb_q;        // |B| (divisor) or unused for multiply
    logic [63:0] acc_q;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        dz_q;

    // Operation decode and operand magnitudes of the latched operands
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // One iteration step and the sign-corrected final result
    logic [32:0] mul_sum_d;
    logic [63:0] mul_acc_d;
    logic [32:0] div_shift_d;
    logic [32:0] div_diff_d;
    logic        div_ge;
    logic [63:0] div_acc_d;
    logic [63:0] step_acc_d;
    logic [63:0] prod_d;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    // Decode the latched operation and derive operand magnitudes
    always_comb begin
        is_div = op_q[1];
        // Signed forms (MULT, DIV) have op_q[0] == 0
        a_neg  = ~op_q[0] & a_q[31];
        b_neg  = ~op_q[0] & b_q[31];
        // 0x80000000 negates to itself, which is its correct unsigned magnitude
        a_mag  = a_neg ? (32'd0 - a_q) : a_q;
        b_mag  = b_neg ? (32'd0 - b_q) : b_q;
    end

    // Compute one shift-add or shift-subtract step and the final HI/LO values
    always_comb begin
        // Multiply: add multiplicand into the upper half when the multiplier LSB
        // is set, then shift the whole 65-bit quantity right by one.
        mul_sum_d   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, ma_q} : 33'd0);
        mul_acc_d   = {mul_sum_d, acc_q[31:1]};

        // Restoring divide: shift the next dividend bit into the remainder and
        // keep the difference only when it does not go negative.
        div_shift_d = {acc_q[63:32], acc_q[31]};
        div_diff_d  = div_shift_d - {1'b0, mb_q};
        div_ge      = ~div_diff_d[32];
        div_acc_d   = {(div_ge ? div_diff_d[31:0] : div_shift_d[31:0]),
                       acc_q[30:0], div_ge};

        step_acc_d  = is_div ? div_acc_d : mul_acc_d;

        prod_d      = (a_neg ^ b_neg) ? (64'd0 - step_acc_d) : step_acc_d;

        if (is_div) begin
            // Quotient takes the sign of A xor B, remainder the sign of A
            lo_d = (a_neg ^ b_neg) ? (32'd0 - step_acc_d[31:0]) : step_acc_d[31:0];
            hi_d = a_neg ? (32'd0 - step_acc_d[63:32]) : step_acc_d[63:32];
        end else begin
            lo_d = prod_d[31:0];
            hi_d = prod_d[63:32];
        end
    end

    // Control FSM with the operand, accumulator and result registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            prep_q  <= 1'b0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'd0;
            ma_q    <= 32'd0;
            mb_q    <= 32'd0;
            acc_q   <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dz_q <= 1'b0;
                    if (bus.start) begin
                        a_q   <= bus.A;
                        b_q   <= bus.B;
                        op_q  <= bus.OP;
                        cnt_q <= 5'd0;
                        if (bus.OP[1] && (bus.B == 32'd0)) begin
                            // Zero divisor: no iteration, HI/LO untouched
                            state_q <= DONE;
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= CALC;
                            prep_q  <= 1'b1;
                        end
                    end
                end

                CALC: begin
                    if (prep_q) begin
                        // Magnitudes are formed once so every iteration works unsigned
                        ma_q   <= a_mag;
                        mb_q   <= b_mag;
                        acc_q  <= is_div ? {32'd0, a_mag} : {32'd0, b_mag};
                        prep_q <= 1'b0;
                    end else begin
                        acc_q <= step_acc_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd31) begin
                            hi_q    <= hi_d;
                            lo_q    <= lo_d;
                            state_q <= DONE;
                        end
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                    dz_q    <= 1'b0;
                end

                default: begin
                    state_q <= IDLE;
                    dz_q    <= 1'b0;
                end
            endcase
        end
    end

    // Status and results are decoded straight from registers
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.dz   = dz_q;

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: the stimulus process pushes hand-computed
// results, a monitor pops and compares whenever done is seen.
module tb_mult_div;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   edge_cnt;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          start_edge;
    } exp_t;

    exp_t sb_q[$];

    mult_div_if bus ();

    mult_div dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each done pulse against the oldest expectation
    always @(negedge clock) begin
        if (reset === 1'b1 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: got done=1 expected no result pending");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("HI", bus.HI, e.hi);
                chk("LO", bus.LO, e.lo);
                chk("dz", {31'd0, bus.dz}, {31'd0, e.dz});
                chk("latency", 32'(edge_cnt - e.start_edge), 32'(e.lat));
                $display("result HI=0x%08h LO=0x%08h dz=%0d latency=%0d",
                         bus.HI, bus.LO, bus.dz, edge_cnt - e.start_edge);
            end
        end
    end

    // Issue one request, optionally pulse a second start mid-operation, and count busy cycles
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                          input int lat, input int busy_exp, input int glitch);
        exp_t e;
        int   n;
        @(negedge clock);
        bus.A     = a;
        bus.B     = b;
        bus.OP    = op;
        bus.start = 1'b1;
        e.hi = hi; e.lo = lo; e.dz = dz; e.lat = lat; e.start_edge = edge_cnt + 1;
        sb_q.push_back(e);
        @(negedge clock);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.OP    = 2'($urandom);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (glitch != 0 && n == glitch) begin
                bus.start = 1'b1;
                bus.A     = 32'd5;
                bus.B     = 32'd5;
                bus.OP    = 2'b01;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clock);
        end
        bus.start = 1'b0;
        chk("busy_cycles", 32'(n), 32'(busy_exp));
        $display("op=%0d A=0x%08h B=0x%08h busy_cycles=%0d", op, a, b, n);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        edge_cnt  = 0;
        reset     = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        bus.OP    = 2'd0;
        bus.start = 1'b1;   // start held during reset must be ignored
        repeat (3) @(negedge clock);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_dz",   {31'd0, bus.dz},   32'd0);
        chk("rst_HI",   bus.HI, 32'd0);
        chk("rst_LO",   bus.LO, 32'd0);
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clock);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 34, 0);
        run_op(2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 34, 0);
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 34, 0);
        run_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 34, 0);
        run_op(2'b01, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 33, 34, 0);
        run_op(2'b11, 32'd100,      32'd0,        32'd0,        32'd6,        1'b1, 0,  1,  0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 34, 0);
        run_op(2'b10, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 1'b0, 33, 34, 0);
        run_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33, 34, 0);
        // Second start during CALC must be ignored
        run_op(2'b01, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 33, 34, 6);

        // Abort an operation with reset partway through CALC
        @(negedge clock);
        bus.A     = 32'h0000FFFF;
        bus.B     = 32'h0000FFFF;
        bus.OP    = 2'b01;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_HI",   bus.HI, 32'd0);
        chk("abort_LO",   bus.LO, 32'd0);
        $display("reset abort busy=%0d HI=0x%08h LO=0x%08h", bus.busy, bus.HI, bus.LO);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run_op(2'b01, 32'd7,        32'd9,        32'd0,        32'd63,       1'b0, 33, 34, 0);
        run_op(2'b10, 32'hFFFFFFFB, 32'd0,        32'd0,        32'd63,       1'b1, 0,  1,  0);

        repeat (5) @(negedge clock);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
